// File: rtl/mfp_eic_port_arb.sv
// mfp_eic_port_arb: boot-time init writer plus round-robin arbiter for the EIC register port,
// with atomic set-bits/clear-bits read-modify-write for mask registers.
module mfp_eic_port_arb #(
   parameter int                    ADDR_WIDTH = 4,
   parameter bit                    INIT_EN    = 1'b1,
   parameter logic [ADDR_WIDTH-1:0] INIT_A0    = '0,
   parameter logic [ADDR_WIDTH-1:0] INIT_A1    = '0,
   parameter logic [ADDR_WIDTH-1:0] INIT_A2    = '0,
   parameter logic [ADDR_WIDTH-1:0] INIT_A3    = '0,
   parameter logic [31:0]           INIT_D0    = 32'h0,
   parameter logic [31:0]           INIT_D1    = 32'h0,
   parameter logic [31:0]           INIT_D2    = 32'h0,
   parameter logic [31:0]           INIT_D3    = 32'h0
) (
   input  logic                  CLK,
   input  logic                  RESETn,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [1:0]            op0,
   input  logic [1:0]            op1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [31:0]           wdata0,
   input  logic [31:0]           wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   output logic [31:0]           rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [31:0]           read_data,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [31:0]           write_data,
   output logic                  write_enable
);

   typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, IDLE, RMW_WR} state_t;

   state_t                  state, state_nx;
   logic                    pri;
   logic [31:0]             old_q, mask_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    clr_q, port_q;
   logic                    init_st, idle, rmw, any_gnt, wr_gnt, rd_gnt, plain_rd;
   logic [1:0]              sel_op;
   logic [ADDR_WIDTH-1:0]   sel_addr, init_a;
   logic [31:0]             sel_wdata, init_d;

   // Decoded state is gated by RESETn so every output clears the moment reset asserts.
   assign init_st = RESETn && state inside {INIT0, INIT1, INIT2, INIT3};
   assign idle    = RESETn && state == IDLE;
   assign rmw     = RESETn && state == RMW_WR;

   // pri=1 means port 1 wins a tie; it points away from the most recent winner.
   assign gnt0      = idle && req0 && (!req1 || !pri);
   assign gnt1      = idle && req1 && (!req0 || pri);
   assign any_gnt   = gnt0 || gnt1;
   assign sel_op    = gnt1 ? op1 : op0;
   assign sel_addr  = gnt1 ? addr1 : addr0;
   assign sel_wdata = gnt1 ? wdata1 : wdata0;
   assign wr_gnt    = any_gnt && sel_op == 2'b01;
   assign rd_gnt    = any_gnt && sel_op != 2'b01;
   assign plain_rd  = any_gnt && sel_op == 2'b00;

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) state <= INIT_EN ? INIT0 : IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = IDLE;
      case (state)
         INIT0:   state_nx = INIT1;
         INIT1:   state_nx = INIT2;
         INIT2:   state_nx = INIT3;
         INIT3:   state_nx = IDLE;
         IDLE:    state_nx = (any_gnt && sel_op[1]) ? RMW_WR : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      init_a       = state == INIT0 ? INIT_A0 : state == INIT1 ? INIT_A1 : state == INIT2 ? INIT_A2 : INIT_A3;
      init_d       = state == INIT0 ? INIT_D0 : state == INIT1 ? INIT_D1 : state == INIT2 ? INIT_D2 : INIT_D3;
      init_done    = idle || rmw;
      write_enable = init_st || rmw || wr_gnt;
      write_addr   = init_st ? init_a : rmw ? addr_q : wr_gnt ? sel_addr : '0;
      write_data   = init_st ? init_d : rmw ? (clr_q ? old_q & ~mask_q : old_q | mask_q) : wr_gnt ? sel_wdata : '0;
      read_addr    = rd_gnt ? sel_addr : '0;
   end

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         done0  <= 1'b0;
         done1  <= 1'b0;
         rdata  <= '0;
         pri    <= 1'b0;
         old_q  <= '0;
         mask_q <= '0;
         addr_q <= '0;
         clr_q  <= 1'b0;
         port_q <= 1'b0;
      end else begin
         done0 <= (gnt0 && !op0[1]) || (rmw && !port_q);
         done1 <= (gnt1 && !op1[1]) || (rmw && port_q);
         if (plain_rd)  rdata <= read_data;
         else if (rmw)  rdata <= old_q;
         if (any_gnt)   pri <= gnt0;
         if (any_gnt && sel_op[1]) begin
            old_q  <= read_data;
            mask_q <= sel_wdata;
            addr_q <= sel_addr;
            clr_q  <= sel_op[0];
            port_q <= gnt1;
         end
      end

endmodule

// File: tb/tb_mfp_eic_port_arb.sv
// tb_mfp_eic_port_arb: cycle table plus hand sequences against a register-file stub of the EIC.
module tb_mfp_eic_port_arb;

   localparam logic [3:0] EICR = 4'd0, EISMSK_0 = 4'd1, EISMSK_1 = 4'd2, EIMSK_0 = 4'd4, EIMSK_1 = 4'd5;

   logic        CLK = 1'b0, RESETn = 1'b0;
   logic        req0, req1, gnt0, gnt1, done0, done1, init_done, write_enable;
   logic [1:0]  op0, op1;
   logic [3:0]  addr0, addr1, read_addr, write_addr;
   logic [31:0] wdata0, wdata1, rdata, read_data, write_data;
   logic [31:0] regs [16];
   logic [3:0]  init_a [4];
   int          ntot = 0, npass = 0;

   always #5 CLK = ~CLK;

   mfp_eic_port_arb #(
      .ADDR_WIDTH(4), .INIT_EN(1'b1),
      .INIT_A0(EICR), .INIT_A1(EISMSK_0), .INIT_A2(EIMSK_0), .INIT_A3(EIMSK_1),
      .INIT_D0(32'd1), .INIT_D1(32'd5), .INIT_D2(32'd3), .INIT_D3(32'd1)
   ) dut (
      .CLK(CLK), .RESETn(RESETn),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .init_done(init_done),
      .read_addr(read_addr), .read_data(read_data),
      .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
   );

   assign read_data = regs[read_addr];
   always @(posedge CLK) if (write_enable) regs[write_addr] <= write_data;

   typedef struct {
      logic r0; logic [1:0] o0; logic [3:0] a0; logic [31:0] w0;
      logic r1; logic [1:0] o1; logic [3:0] a1; logic [31:0] w1;
      logic g0, g1, d0, d1, we; logic [3:0] wa; logic [31:0] wd;
      logic idn, rchk; logic [31:0] rd;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else npass++;
   endtask

   task automatic drive(input vec_t v);
      req0 = v.r0; op0 = v.o0; addr0 = v.a0; wdata0 = v.w0;
      req1 = v.r1; op1 = v.o1; addr1 = v.a1; wdata1 = v.w1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      init_a = '{EICR, EISMSK_0, EIMSK_0, EIMSK_1};
      //          r0 o0 a0       w0  r1 o1 a1       w1  g0 g1 d0 d1 we wa       wd idn rchk rd
      tbl[0]  = '{1, 1, EIMSK_0, 3,  0, 0, 0,       0,  0, 0, 0, 0, 1, EICR,    1, 0, 0, 0};
      tbl[1]  = '{1, 1, EIMSK_0, 3,  0, 0, 0,       0,  0, 0, 0, 0, 1, EISMSK_0,5, 0, 0, 0};
      tbl[2]  = '{1, 1, EIMSK_0, 3,  0, 0, 0,       0,  0, 0, 0, 0, 1, EIMSK_0, 3, 0, 0, 0};
      tbl[3]  = '{1, 1, EIMSK_0, 3,  0, 0, 0,       0,  0, 0, 0, 0, 1, EIMSK_1, 1, 0, 0, 0};
      tbl[4]  = '{1, 1, EIMSK_0, 3,  0, 0, 0,       0,  1, 0, 0, 0, 1, EIMSK_0, 3, 1, 0, 0};
      tbl[5]  = '{1, 0, EIMSK_0, 0,  0, 0, 0,       0,  1, 0, 1, 0, 0, 0,       0, 1, 1, 0};
      tbl[6]  = '{0, 0, 0,       0,  0, 0, 0,       0,  0, 0, 1, 0, 0, 0,       0, 1, 1, 3};
      tbl[7]  = '{1, 0, EISMSK_0,0,  1, 0, EIMSK_1, 0,  0, 1, 0, 0, 0, 0,       0, 1, 0, 0};
      tbl[8]  = '{1, 0, EISMSK_0,0,  1, 0, EIMSK_1, 0,  1, 0, 0, 1, 0, 0,       0, 1, 1, 1};
      tbl[9]  = '{1, 0, EISMSK_0,0,  1, 0, EIMSK_1, 0,  0, 1, 1, 0, 0, 0,       0, 1, 1, 5};
      tbl[10] = '{1, 0, EISMSK_0,0,  1, 0, EIMSK_1, 0,  1, 0, 0, 1, 0, 0,       0, 1, 1, 1};
      tbl[11] = '{0, 0, 0,       0,  0, 0, 0,       0,  0, 0, 1, 0, 0, 0,       0, 1, 1, 5};
      tbl[12] = '{0, 0, 0,       0,  1, 2, EIMSK_0, 4,  0, 1, 0, 0, 0, 0,       0, 1, 0, 0};
      tbl[13] = '{1, 0, EIMSK_0, 0,  0, 0, 0,       0,  0, 0, 0, 0, 1, EIMSK_0, 7, 1, 0, 0};
      tbl[14] = '{1, 0, EIMSK_0, 0,  0, 0, 0,       0,  1, 0, 0, 1, 0, 0,       0, 1, 1, 3};
      tbl[15] = '{0, 0, 0,       0,  1, 3, EIMSK_0, 1,  0, 1, 1, 0, 0, 0,       0, 1, 1, 7};
      tbl[16] = '{0, 0, 0,       0,  0, 0, 0,       0,  0, 0, 0, 0, 1, EIMSK_0, 6, 1, 0, 0};
      tbl[17] = '{0, 0, 0,       0,  0, 0, 0,       0,  0, 0, 0, 1, 0, 0,       0, 1, 1, 7};

      drive(tbl[0]);
      @(negedge CLK);
      chk("rst_we", write_enable, 0);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_done0", done0, 0);
      chk("rst_rdata", rdata, 0);

      for (int i = 0; i < 18; i++) begin
         @(posedge CLK); #1;
         if (i == 0) RESETn = 1'b1;
         drive(tbl[i]);
         @(negedge CLK);
         chk($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
         chk($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
         chk($sformatf("v%0d_done0", i), done0, tbl[i].d0);
         chk($sformatf("v%0d_done1", i), done1, tbl[i].d1);
         chk($sformatf("v%0d_we", i), write_enable, tbl[i].we);
         chk($sformatf("v%0d_init_done", i), init_done, tbl[i].idn);
         if (tbl[i].we) begin
            chk($sformatf("v%0d_waddr", i), write_addr, tbl[i].wa);
            chk($sformatf("v%0d_wdata", i), write_data, tbl[i].wd);
         end
         if (tbl[i].rchk) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      end

      // Reset pulsed in the middle of a port-1 set-bits on EIMSK_1.
      @(posedge CLK); #1;
      req1 = 1; op1 = 2'b10; addr1 = EIMSK_1; wdata1 = 32'h2;
      @(negedge CLK);
      chk("rmw_rst_gnt1", gnt1, 1);
      @(posedge CLK); #1;
      req1 = 0;
      @(negedge CLK);
      chk("rmw_rst_we_before", write_enable, 1);
      chk("rmw_rst_wdata_before", write_data, 32'h3);
      #1 RESETn = 1'b0;
      #1;
      chk("rmw_rst_we_async", write_enable, 0);
      chk("rmw_rst_init_done_async", init_done, 0);
      req0 = 1; op0 = 2'b00; addr0 = EISMSK_1;
      req1 = 1; op1 = 2'b00; addr1 = EISMSK_0;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rmw_rst_no_done1", done1, 0);
      chk("rmw_rst_write_lost", regs[EIMSK_1], 32'h1);
      regs[EIMSK_0] = 32'h0;

      @(posedge CLK); #1;
      RESETn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k < 4) begin
            chk($sformatf("reinit%0d_we", k), write_enable, 1);
            chk($sformatf("reinit%0d_waddr", k), write_addr, init_a[k]);
            chk($sformatf("reinit%0d_gnt0", k), gnt0, 0);
         end else begin
            chk($sformatf("rr%0d_gnt0", k), gnt0, k % 2 == 0);
            chk($sformatf("rr%0d_gnt1", k), gnt1, k % 2 == 1);
            chk($sformatf("rr%0d_init_done", k), init_done, 1);
         end
         if (k == 5) begin
            chk("rr5_done0", done0, 1);
            chk("rr5_rdata", rdata, 32'h0);
         end
         if (k == 6) begin
            chk("rr6_done1", done1, 1);
            chk("rr6_rdata", rdata, 32'h5);
         end
         @(posedge CLK); #1;
      end
      chk("reinit_eimsk0", regs[EIMSK_0], 32'h3);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
